// File: rtl/alu_result_buffer.sv
// alu_result_buffer: DEPTH-entry FIFO of ALU results {addr,data} draining into
// the operand cache write port. Head is shown first-word-fall-through, and a
// full buffer still accepts a result in any cycle where the head drains.
// Optional forwarding lookup is compiled only with ALU_RESULT_BUF_FWD_LOOKUP_EN;
// without it, lookup_hit_o/lookup_data_o are constant 0.
// DEPTH must be a power of two and at least 2, so the pointers wrap for free.

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module alu_result_buffer #(
  parameter int unsigned DATA_WIDTH = `WORD_WIDTH,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  // result offer from the ALU
  input  logic                          in_valid_i,
  input  logic [ADDR_WIDTH-1:0]         in_addr_i,
  input  logic [DATA_WIDTH-1:0]         in_data_i,
  output logic                          store_success_o,
  // drain toward the operand cache write port
  output logic                          wr_valid_o,
  output logic [ADDR_WIDTH-1:0]         wr_addr_o,
  output logic [DATA_WIDTH-1:0]         wr_data_o,
  input  logic                          wr_ready_i,
  // occupancy
  output logic [$clog2(DEPTH):0]        count_o,
  // forwarding lookup
  input  logic [ADDR_WIDTH-1:0]         lookup_addr_i,
  output logic                          lookup_hit_o,
  output logic [DATA_WIDTH-1:0]         lookup_data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_d [DEPTH];

  logic empty_c;
  logic full_c;
  logic push_c;
  logic pop_c;

  // Handshake: a full buffer can still take a result when the head leaves now.
  always_comb begin
    empty_c         = (count_q == '0);
    full_c          = (count_q == CNT_W'(DEPTH));
    wr_valid_o      = !empty_c;
    store_success_o = in_valid_i & (!full_c | wr_ready_i);
    push_c          = store_success_o;
    pop_c           = wr_valid_o & wr_ready_i;
  end

  // Head entry presented first-word-fall-through; zero while empty.
  always_comb begin
    wr_addr_o = '0;
    wr_data_o = '0;
    if (!empty_c) begin
      wr_addr_o = addr_mem_q[rd_ptr_q];
      wr_data_o = data_mem_q[rd_ptr_q];
    end
  end

  assign count_o = count_q;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage write: the accepted result lands at the tail slot.
  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    if (push_c) begin
      addr_mem_d[wr_ptr_q] = in_addr_i;
      data_mem_d[wr_ptr_q] = in_data_i;
    end
  end

  // Control state; reset discards every entry by clearing pointers and count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; validity comes from the count.
  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

`ifdef ALU_RESULT_BUF_FWD_LOOKUP_EN
  logic [PTR_W-1:0] lk_idx_c;

  // Youngest valid match wins: scan oldest to youngest and keep the last hit.
  // The head still counts while it pops; a same-cycle push is not yet stored.
  always_comb begin
    lookup_hit_o  = 1'b0;
    lookup_data_o = '0;
    lk_idx_c      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      lk_idx_c = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_mem_q[lk_idx_c] == lookup_addr_i)) begin
        lookup_hit_o  = 1'b1;
        lookup_data_o = data_mem_q[lk_idx_c];
      end
    end
  end
`else
  logic unused_lookup_addr;

  // Forwarding not built: constant outputs, lookup address ignored.
  assign unused_lookup_addr = ^lookup_addr_i;
  assign lookup_hit_o       = 1'b0;
  assign lookup_data_o      = '0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomised self-checking bench for alu_result_buffer against a queue model.
module tb_alu_result_buffer;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 4;

`ifdef ALU_RESULT_BUF_FWD_LOOKUP_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid_i = 1'b0;
  logic [AW-1:0] in_addr_i = '0;
  logic [DW-1:0] in_data_i = '0;
  logic          store_success_o;
  logic          wr_valid_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          wr_ready_i = 1'b0;
  logic [2:0]    count_o;
  logic [AW-1:0] lookup_addr_i = '0;
  logic          lookup_hit_o;
  logic [DW-1:0] lookup_data_o;

  int tests = 0;
  int fails = 0;
  entry_t q[$];

  alu_result_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid_i(in_valid_i), .in_addr_i(in_addr_i), .in_data_i(in_data_i),
    .store_success_o(store_success_o),
    .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .wr_ready_i(wr_ready_i), .count_o(count_o),
    .lookup_addr_i(lookup_addr_i), .lookup_hit_o(lookup_hit_o),
    .lookup_data_o(lookup_data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a plain queue; accept if room or the head leaves, pop from front.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
    end else begin
      automatic bit acc = in_valid_i && (q.size() < DEPTH || wr_ready_i);
      automatic bit pop = (q.size() != 0) && wr_ready_i;
      entry_t e;
      e.a = in_addr_i;
      e.d = in_data_i;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  end

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    automatic logic          e_ss  = in_valid_i && (q.size() < DEPTH || wr_ready_i);
    automatic logic          e_v   = (q.size() != 0);
    automatic logic [AW-1:0] e_a   = e_v ? q[0].a : '0;
    automatic logic [DW-1:0] e_d   = e_v ? q[0].d : '0;
    automatic logic          e_hit = 1'b0;
    automatic logic [DW-1:0] e_ld  = '0;
    if (FWD) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a == lookup_addr_i) begin
          e_hit = 1'b1;
          e_ld  = q[i].d;
          break;
        end
      end
    end
    chk("store_success", 32'(store_success_o), 32'(e_ss));
    chk("wr_valid", 32'(wr_valid_o), 32'(e_v));
    chk("wr_addr", 32'(wr_addr_o), 32'(e_a));
    chk("wr_data", 32'(wr_data_o), 32'(e_d));
    chk("count", 32'(count_o), 32'(q.size()));
    chk("lookup_hit", 32'(lookup_hit_o), 32'(e_hit));
    chk("lookup_data", 32'(lookup_data_o), 32'(e_ld));
  end

  // One cycle of stimulus; returns at the following falling edge.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic r, input logic [AW-1:0] la);
    @(posedge clk);
    #1;
    in_valid_i    = v;
    in_addr_i     = a;
    in_data_i     = d;
    wr_ready_i    = r;
    lookup_addr_i = la;
    @(negedge clk);
  endtask

  initial begin
    // reset state
    #2;
    chk("reset_wr_valid", 32'(wr_valid_o), 32'h0);
    chk("reset_count", 32'(count_o), 32'h0);
    chk("reset_lookup_hit", 32'(lookup_hit_o), 32'h0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    // single push, no bypass, visible next cycle
    step(1'b1, 8'h05, 16'h1234, 1'b0, 8'h00);
    chk("push_ack", 32'(store_success_o), 32'h1);
    chk("no_bypass", 32'(wr_valid_o), 32'h0);
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    chk("first_valid", 32'(wr_valid_o), 32'h1);
    chk("first_addr", 32'(wr_addr_o), 32'h05);
    chk("first_data", 32'(wr_data_o), 32'h1234);
    chk("first_count", 32'(count_o), 32'h1);
    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'h00);
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    chk("drained_count", 32'(count_o), 32'h0);

    // fill past capacity, then drain in order
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, AW'(8'h10 + i), DW'(i), 1'b0, 8'h00);
      chk("fill_ack", 32'(store_success_o), (i <= 4) ? 32'h1 : 32'h0);
    end
    chk("full_count", 32'(count_o), 32'h4);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 8'h00, 16'h0000, 1'b1, 8'h00);
      chk("drain_order", 32'(wr_data_o), 32'(i));
    end
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    chk("empty_valid", 32'(wr_valid_o), 32'h0);
    chk("empty_addr", 32'(wr_addr_o), 32'h0);
    chk("empty_data", 32'(wr_data_o), 32'h0);

    // full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) step(1'b1, 8'h20, DW'(8'h20 + i), 1'b0, 8'h00);
    step(1'b1, 8'h30, 16'h0025, 1'b1, 8'h00);
    chk("full_pushpop_ack", 32'(store_success_o), 32'h1);
    chk("full_pushpop_head", 32'(wr_data_o), 32'h21);
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    chk("full_pushpop_count", 32'(count_o), 32'h4);
    chk("full_pushpop_newhead", 32'(wr_data_o), 32'h22);
    for (int i = 2; i <= 5; i++) begin
      step(1'b0, 8'h00, 16'h0000, 1'b1, 8'h00);
      chk("full_pushpop_order", 32'(wr_data_o), 32'(8'h20 + i));
    end
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);

    // forwarding lookup: youngest match wins
    step(1'b1, 8'h07, 16'hAAAA, 1'b0, 8'h00);
    step(1'b1, 8'h07, 16'hBBBB, 1'b0, 8'h00);
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h07);
    chk("lookup07_hit", 32'(lookup_hit_o), FWD ? 32'h1 : 32'h0);
    chk("lookup07_data", 32'(lookup_data_o), FWD ? 32'hBBBB : 32'h0);
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h08);
    chk("lookup08_hit", 32'(lookup_hit_o), 32'h0);
    chk("lookup08_data", 32'(lookup_data_o), 32'h0);

    // asynchronous reset mid-cycle with three entries
    step(1'b1, 8'h09, 16'hCCCC, 1'b0, 8'h00);
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    chk("pre_reset_count", 32'(count_o), 32'h3);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(wr_valid_o), 32'h0);
    chk("async_reset_count", 32'(count_o), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 8'h01, 16'h0101, 1'b0, 8'h00);
    chk("post_reset_ack", 32'(store_success_o), 32'h1);
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    chk("post_reset_addr", 32'(wr_addr_o), 32'h01);
    chk("post_reset_data", 32'(wr_data_o), 32'h0101);

    // continuous push and pop across pointer wrap
    for (int i = 0; i < 20; i++) begin
      step(1'b1, AW'(i), DW'(16'h0100 + i), 1'b1, 8'h00);
      chk("stream_count", 32'(count_o), 32'h1);
    end

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 99) < 60), AW'($urandom_range(0, 7)), DW'($urandom),
           1'($urandom_range(0, 99) < 45), AW'($urandom_range(0, 7)));
      if (i == 1500) begin
        #2 reset_n = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
      end
    end

    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'h00);
    repeat (6) step(1'b0, 8'h00, 16'h0000, 1'b1, 8'h00);
    chk("final_empty", 32'(count_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `WORD_WIDTH, result data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, destination operand address width.
REQ-003 SHALL have parameter DEPTH, default 4, entry count, power of two, >=2.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports in_valid_i  in  1, in_addr_i  in  ADDR_WIDTH, in_data_i  in  DATA_WIDTH: ALU result offer (opd_valid/opd_addr/opd_data).
REQ-007 SHALL have port store_success_o  out  1  result accepted this cycle; returned to the ALU as opd_store_success.
REQ-008 SHALL have ports wr_valid_o  out  1, wr_addr_o  out  ADDR_WIDTH, wr_data_o  out  DATA_WIDTH, wr_ready_i  in  1: drain to operand cache write port.
REQ-009 SHALL have port count_o  out  $clog2(DEPTH)+1  current occupancy.
REQ-010 SHALL have ports lookup_addr_i  in  ADDR_WIDTH, lookup_hit_o  out  1, lookup_data_o  out  DATA_WIDTH: forwarding lookup.

Function
REQ-011 SHALL be a FIFO of DEPTH {addr,data} entries with read/write pointers wrapping modulo DEPTH.
REQ-012 SHALL define push = in_valid_i & store_success_o, pop = wr_valid_o & wr_ready_i.
REQ-013 SHALL drive store_success_o combinationally = in_valid_i & (count_o < DEPTH | wr_ready_i).
REQ-014 SHALL, when full with pop and push in the same cycle, accept the push; count unchanged.
REQ-015 SHALL, when empty, hold wr_valid_o low; no same-cycle bypass; pushed entry appears on wr_* exactly one cycle after push.
REQ-016 SHALL present the head entry on wr_addr_o/wr_data_o first-word-fall-through; wr_valid_o = (count_o != 0).
REQ-017 SHALL hold wr_addr_o/wr_data_o stable while wr_valid_o=1 and wr_ready_i=0.
REQ-018 SHALL update count_o: +1 push only, -1 pop only, unchanged both/neither; never exceeds DEPTH nor underflows.
REQ-019 SHALL preserve push order on drain; duplicate addresses allowed, each drained separately.
REQ-020 SHALL ignore in_addr_i/in_data_i when in_valid_i=0; wr_ready_i with empty buffer has no effect.
REQ-021 SHALL drive wr_addr_o/wr_data_o to 0 when empty.

Reset
REQ-022 SHALL on reset_n low asynchronously clear pointers and count; outputs: store_success_o follows REQ-013 with count 0, wr_valid_o=0, wr_addr_o=0, wr_data_o=0, count_o=0, lookup_hit_o=0, lookup_data_o=0.
REQ-023 SHALL discard all entries on reset mid-operation; storage array contents need not be cleared.
REQ-024 SHALL resume accepting on the first rising edge after reset_n deasserts.

Configuration
REQ-025 SHALL compile forwarding lookup only when macro ALU_RESULT_BUF_FWD_LOOKUP_EN is defined.
REQ-026 SHALL with macro defined: lookup_hit_o combinationally 1 if any valid entry has addr == lookup_addr_i; lookup_data_o = data of youngest matching valid entry, else 0; entry popping this cycle still counts; same-cycle push not visible.
REQ-027 SHALL without macro: lookup_hit_o=0, lookup_data_o=0 constant, no comparators synthesised.

Verification
REQ-028 Reset, push addr 0x05 data 0x1234 wr_ready_i=0 -> store_success_o=1; next cycle wr_valid_o=1, wr_addr_o=0x05, wr_data_o=0x1234, count_o=1.
REQ-029 DEPTH=4, wr_ready_i=0, push 5 values -> first 4 acknowledged, 5th store_success_o=0, count_o=4; raise wr_ready_i -> drained in order 1..4.
REQ-030 Full buffer, in_valid_i=1 and wr_ready_i=1 same cycle -> store_success_o=1, head popped, new value at tail, count_o stays 4.
REQ-031 Push 0x07/0xAAAA then 0x07/0xBBBB, lookup 0x07 with macro -> hit=1, data=0xBBBB; lookup 0x08 -> hit=0, data=0; without macro -> hit=0 always.
REQ-032 Reset_n asserted with 3 entries, mid-cycle -> wr_valid_o=0, count_o=0 immediately; after release, push 0x01 -> appears next cycle.
REQ-033 Continuous push and pop 20 cycles, pointers wrapping -> output sequence equals input sequence, count_o constant.
